// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters share one single-port RAM through an IDLE/ACCESS/RESP FSM.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise p0 has fixed priority.
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p1_wdata,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic        p0_err,
    output logic        p1_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        we_q;
    logic        mis_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        grant_sel;
    logic        start;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

`ifdef MEM_ARBITER_RR_EN
    logic last_grant;

    // A lone requester always wins; on contention the port not served last goes first.
    always_comb begin
        grant_sel = p1_req;
        if (p0_req && p1_req) begin
            grant_sel = ~last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            last_grant <= 1'b1;
        end else if (start) begin
            last_grant <= grant_sel;
        end
    end
`else
    assign grant_sel = p1_req & ~p0_req;
`endif

    assign start     = (state == IDLE) && (p0_req || p1_req);
    assign sel_we    = grant_sel ? p1_we    : p0_we;
    assign sel_addr  = grant_sel ? p1_addr  : p0_addr;
    assign sel_wdata = grant_sel ? p1_wdata : p0_wdata;

    assign mem_addr   = addr_q;
    assign mem_datain = wdata_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        next_state = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        p0_ack     = 1'b0;
        p1_ack     = 1'b0;
        p0_err     = 1'b0;
        p1_err     = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    // Misaligned requests never touch the RAM.
                    next_state = (sel_addr[1:0] != 2'b00) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_read  = ~we_q;
                mem_write = we_q;
                if (cnt == LAST_CNT) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                busy       = 1'b1;
                p0_ack     = ~owner;
                p1_ack     = owner;
                p0_err     = ~owner & mis_q;
                p1_err     = owner & mis_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured once at grant; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt     <= 4'd0;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata   <= 32'd0;
        end else if (start) begin
            cnt     <= 4'd0;
            owner   <= grant_sel;
            we_q    <= sel_we;
            mis_q   <= (sel_addr[1:0] != 2'b00);
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end else if (state == ACCESS) begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_CNT && !we_q) begin
                rdata <= mem_dataout;
            end
        end
    end

endmodule
